lcd_write_engine: RTL and testbench

Parametrised HD44780 character-LCD write engine for the DE2 16x2 LCD. It buffers instruction and data bytes from a valid/ready stream in an internal FIFO. For each byte it generates the RS/RW/EN/DATA bus cycle with programmable setup, pulse, hold and execution-wait timing, and it can run the power-on initialisation sequence autonomously. It sits between the application logic (text/cursor generators) and the board LCD pins.

---
 rtl/lcd_write_engine.sv | 197 +++++++++++++++++++
 tb/tb_lcd_write_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_engine.sv
// HD44780 character-LCD write engine: byte FIFO feeding a timed RS/RW/EN/DATA bus cycle.
// Define LCD_INIT_SEQ_EN to add the autonomous power-up wait and init instruction sequence.
module lcd_write_engine #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int FIFO_DEPTH     = 16,
  parameter int SETUP_CYC      = 3,
  parameter int EN_CYC         = 25,
  parameter int HOLD_CYC       = 3,
  parameter int SHORT_WAIT_CYC = 2000,
  parameter int LONG_WAIT_CYC  = 82000,
  parameter int POWERUP_CYC    = 750000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       busy,
  output logic       init_done,
  output logic [7:0] LCD_DATA,
  output logic       LCD_EN,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_ON,
  output logic       LCD_BLON
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max_of(max_of(max_of(SETUP_CYC, EN_CYC), max_of(HOLD_CYC, SHORT_WAIT_CYC)),
                                  max_of(LONG_WAIT_CYC, POWERUP_CYC));
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t SETUP_LD = cnt_t'(SETUP_CYC - 1);
  localparam cnt_t EN_LD    = cnt_t'(EN_CYC - 1);
  localparam cnt_t HOLD_LD  = cnt_t'(HOLD_CYC - 1);
  localparam cnt_t SHORT_LD = cnt_t'(SHORT_WAIT_CYC - 1);
  localparam cnt_t LONG_LD  = cnt_t'(LONG_WAIT_CYC - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

  if (CLK_HZ < 1 || FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("lcd_write_engine: invalid parameter set");
  end

  typedef enum logic [2:0] {PWRUP, IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

  state_t          state;
  cnt_t            cnt;
  logic            active;
  logic [8:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            push, pop, init_left, long_wait;

  // Handshake: a byte transfers on every rising edge where wr_valid && wr_ready;
  // wr_ready depends only on FIFO occupancy, so a full FIFO refuses even when popping.
  assign wr_ready  = active && (count != FULL);
  assign push      = wr_valid && wr_ready;
  assign pop       = (state == IDLE) && !init_left && (count != '0);
  assign long_wait = !LCD_RS && (LCD_DATA != 8'h00) && (LCD_DATA[7:2] == 6'd0);
  assign busy      = !active || (state != IDLE) || (count != '0) || init_left;
  assign LCD_RW    = 1'b0;
  assign LCD_ON    = active;
  assign LCD_BLON  = active;

`ifdef LCD_INIT_SEQ_EN
  localparam cnt_t PWRUP_LAST = cnt_t'(POWERUP_CYC - 1);
  localparam state_t RESET_STATE = PWRUP;
  logic [2:0] init_idx;
  logic [7:0] init_byte;
  assign init_left = (init_idx != 3'd4);
  always_comb begin
    init_byte = 8'h06;
    case (init_idx[1:0])
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  end
`else
  localparam state_t RESET_STATE = IDLE;
  assign init_left = 1'b0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= {wr_rs, wr_data};
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // One counter times every state; it counts up only while waiting for power-up.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state     <= RESET_STATE;
      cnt       <= '0;
      active    <= 1'b0;
      init_done <= 1'b0;
      LCD_EN    <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_DATA  <= 8'h00;
`ifdef LCD_INIT_SEQ_EN
      init_idx  <= 3'd0;
`endif
    end else begin
      active <= 1'b1;
`ifndef LCD_INIT_SEQ_EN
      init_done <= 1'b1;
`endif
      case (state)
`ifdef LCD_INIT_SEQ_EN
        PWRUP: begin
          if (cnt == PWRUP_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        IDLE: begin
`ifdef LCD_INIT_SEQ_EN
          if (init_left) begin
            LCD_RS   <= 1'b0;
            LCD_DATA <= init_byte;
            init_idx <= init_idx + 3'd1;
            cnt      <= SETUP_LD;
            state    <= SETUP;
          end else
`endif
          if (pop) begin
            {LCD_RS, LCD_DATA} <= mem[rd_ptr];
            cnt                <= SETUP_LD;
            state              <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            LCD_EN <= 1'b1;
            cnt    <= EN_LD;
            state  <= PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            LCD_EN <= 1'b0;
            cnt    <= HOLD_LD;
            state  <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cnt   <= long_wait ? LONG_LD : SHORT_LD;
            state <= WAIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= IDLE;
`ifdef LCD_INIT_SEQ_EN
            if (!init_left) init_done <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_engine.sv
// Bench for lcd_write_engine: schedule model of byte emission times plus directed vectors.
module tb_lcd_write_engine;

  localparam int DEPTH = 16;
  localparam int S     = 3;
  localparam int E     = 5;
  localparam int H     = 2;
  localparam int SW    = 10;
  localparam int LW    = 40;
  localparam int P     = 50;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, busy, init_done;
  logic [7:0] LCD_DATA;
  logic       LCD_EN, LCD_RW, LCD_RS, LCD_ON, LCD_BLON;

  always #5 clk = ~clk;

  lcd_write_engine #(
    .CLK_HZ(50_000_000), .FIFO_DEPTH(DEPTH), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H),
    .SHORT_WAIT_CYC(SW), .LONG_WAIT_CYC(LW), .POWERUP_CYC(P)
  ) dut (
    .CLOCK_50(clk), .RESET(RESET), .wr_valid(wr_valid), .wr_rs(wr_rs), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .init_done(init_done), .LCD_DATA(LCD_DATA),
    .LCD_EN(LCD_EN), .LCD_RW(LCD_RW), .LCD_RS(LCD_RS), .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON)
  );

  int checks = 0;
  int failures = 0;
  int cyc = -2;

  // Cycle 0 is the first cycle after RESET is released.
  always @(posedge clk) cyc <= RESET ? -1 : cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: every byte gets an EN rise cycle from the engine's free time and its arrival.
  logic [40:0] exp_q[$];
  int          rise_log[$];
  int          t_free = 0;
  int          init_done_cyc = 0;

  function automatic int wait_of(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? LW : SW;
  endfunction

  task automatic model_add(input logic rs, input logic [7:0] d, input int avail);
    int pop_c;
    pop_c = (t_free > avail) ? t_free : avail;
    exp_q.push_back({32'(pop_c + 1 + S), rs, d});
    t_free = pop_c + 1 + S + E + H + wait_of(rs, d);
  endtask

  task automatic model_reset();
    exp_q.delete();
`ifdef LCD_INIT_SEQ_EN
    t_free = P;
    model_add(1'b0, 8'h38, 0);
    model_add(1'b0, 8'h0C, 0);
    model_add(1'b0, 8'h01, 0);
    model_add(1'b0, 8'h06, 0);
    init_done_cyc = t_free;
`else
    t_free = 0;
    init_done_cyc = 0;
`endif
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin
    bit          prev_en, in_pulse, rose;
    int          hold_left, rise_cyc, last_change;
    logic [8:0]  cap, prev_bus, bus;
    logic [40:0] e;
    prev_en = 0; in_pulse = 0; hold_left = 0; rise_cyc = 0; last_change = -1;
    cap = '0; prev_bus = '0;
    forever begin
      @(negedge clk);
      if (cyc < 0) begin
        prev_en = 0; in_pulse = 0; hold_left = 0; prev_bus = '0; last_change = -1;
      end else begin
        bus  = {LCD_RS, LCD_DATA};
        rose = 0;
        check("rw_low", LCD_RW, 1'b0);
        check("lcd_on", {LCD_ON, LCD_BLON}, 2'b11);
        check("busy", busy, cyc < t_free);
        check("init_done", init_done, cyc >= init_done_cyc);
        if (bus !== prev_bus) last_change = cyc;
        if (LCD_EN && !prev_en) begin
          rose = 1;
          rise_log.push_back(cyc);
          check("pulse_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rise_cycle", cyc, e[40:9]);
            check("rs_data", bus, e[8:0]);
            check("setup_time", (cyc - last_change) >= S, 1'b1);
          end
          in_pulse = 1; rise_cyc = cyc; cap = bus;
        end else if (!LCD_EN && prev_en) begin
          check("en_width", cyc - rise_cyc, E);
          in_pulse = 0; hold_left = H;
        end
        if (!rose && (in_pulse || hold_left > 0)) begin
          check("bus_stable", bus, cap);
          if (!in_pulse) hold_left--;
        end
        prev_en = LCD_EN; prev_bus = bus;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    wr_valid = 1'b0;
    tick();
    model_reset();
    @(negedge clk);
    check("rst_en", LCD_EN, 1'b0);
    check("rst_rw", LCD_RW, 1'b0);
    check("rst_rs", LCD_RS, 1'b0);
    check("rst_data", LCD_DATA, 8'h00);
    check("rst_on", LCD_ON, 1'b0);
    check("rst_blon", LCD_BLON, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_init_done", init_done, 1'b0);
    RESET = 1'b0;
    tick();
  endtask

  task automatic push(input logic rs, input logic [7:0] d, output int acc);
    int n;
    bit done;
    n = 0; done = 0; acc = -1;
    wr_valid = 1'b1; wr_rs = rs; wr_data = d;
    while (!done && n < 500) begin
      @(negedge clk);
      if (wr_ready) begin
        done = 1;
        acc = cyc;
      end
      @(posedge clk);
      if (done) model_add(rs, d, acc + 1);
      #1;
      n++;
    end
    wr_valid = 1'b0;
    check("push_accepted", done, 1'b1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cyc < t_free) && n < 5000) begin
      tick();
      n++;
    end
    check("drained", (exp_q.size() == 0) && (cyc >= t_free), 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, n;
    do_reset();
    @(negedge clk);
    check("wr_ready_after_reset", wr_ready, 1'b1);
`ifdef LCD_INIT_SEQ_EN
    check("init_done_after_reset", init_done, 1'b0);
`else
    check("init_done_after_reset", init_done, 1'b1);
`endif
    tick();

`ifdef LCD_INIT_SEQ_EN
    wait_drain();
    check("init_pulse_count", rise_log.size(), 4);
    // P idle cycles, then IDLE + S setup cycles: 50 + 1 + 3.
    check("init_first_rise", rise_log[0], 54);
    // 0x01 uses the long wait: 1 + 3 + 5 + 2 + 40.
    check("init_clear_period", rise_log[3] - rise_log[2], 51);
    check("init_done_high", init_done, 1'b1);
`endif

    // Long byte first, then overfill the FIFO while it executes.
    rise_log.delete();
    push(1'b0, 8'h01, a);
    for (int i = 0; i < 16; i++) push(i[0], 8'h40 + 8'(i), b);
    @(negedge clk);
    check("wr_ready_full", wr_ready, 1'b0);
    tick();
    push(1'b1, 8'h50, b);
    wait_drain();
    check("pop_to_en_rise", rise_log[0] - a, 5);
    check("fifo_pulse_count", rise_log.size(), 18);

    // Long then short byte period, back to back.
    rise_log.delete();
    push(1'b0, 8'h02, a);
    push(1'b0, 8'h80, a);
    push(1'b1, 8'h48, a);
    wait_drain();
    check("long_period", rise_log[1] - rise_log[0], 51);
    check("short_period", rise_log[2] - rise_log[1], 21);

    // Reset while EN is high with bytes still queued.
    push(1'b1, 8'h10, a);
    push(1'b1, 8'h11, a);
    push(1'b1, 8'h12, a);
    n = 0;
    while (!LCD_EN && n < 200) begin
      tick();
      n++;
    end
    check("en_high_before_reset", LCD_EN, 1'b1);
    do_reset();
    rise_log.delete();
    repeat (30) tick();
`ifdef LCD_INIT_SEQ_EN
    wait_drain();
    check("reinit_pulse_count", rise_log.size(), 4);
`else
    check("flushed_no_pulse", rise_log.size(), 0);
    check("flushed_idle", busy, 1'b0);
`endif
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
